// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clk_div_bank divider bank.
package clk_div_pkg;

  localparam int          CNT_W_DEFAULT       = 25;
  localparam int unsigned DEFAULT_DIV_DEFAULT = 32'd25_000_000;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle between a host and the clk_div_bank divider bank.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEFAULT
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] enable;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_value;
  logic              sync_pulse;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_slow;
  logic [NUM_CH-1:0] load_pending;

  modport master (
    output enable, div_we, div_sel, div_value, sync_pulse,
    input  tick, clk_slow, load_pending
  );

  modport slave (
    input  enable, div_we, div_sel, div_value, sync_pulse,
    output tick, clk_slow, load_pending
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: up-counter, shadow/active divisor, tick strobe and toggle enable.
// Phase-align input exists only when CLKDIV_PHASE_ALIGN_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic             i_sync,
`endif
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_clk_slow,
  output logic             o_load_pending
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] r_div_shadow;
  logic             r_tick;
  logic             r_clk_slow;
  logic             r_load_pending;

  logic w_stopped;
  logic w_term;
  logic w_apply_idle;

  assign w_stopped = (r_div_active == '0);
  // div_active-1 is only meaningful when not stopped, so no underflow reaches w_term.
  assign w_term    = i_en && !w_stopped && (r_count == r_div_active - CNT_W'(1));
  // A disabled or stopped channel has no period boundary to wait for.
  assign w_apply_idle = r_load_pending && (!i_en || w_stopped);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count        <= '0;
      r_div_active   <= DIV_RST;
      r_div_shadow   <= DIV_RST;
      r_tick         <= 1'b0;
      r_clk_slow     <= 1'b0;
      r_load_pending <= 1'b0;
    end
`ifdef CLKDIV_PHASE_ALIGN_EN
    else if (i_sync) begin
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_clk_slow <= 1'b0;
      if (r_load_pending) begin
        r_div_active <= r_div_shadow;
      end
      // A write on the align edge must wait for a later boundary.
      if (i_we) begin
        r_div_shadow   <= i_div;
        r_load_pending <= 1'b1;
      end else begin
        r_load_pending <= 1'b0;
      end
    end
`endif
    else begin
      r_tick <= 1'b0;
      if (w_stopped) begin
        r_count    <= '0;
        r_clk_slow <= 1'b0;
      end else if (i_en) begin
        if (w_term) begin
          r_count    <= '0;
          r_tick     <= 1'b1;
          r_clk_slow <= ~r_clk_slow;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      if (i_we) begin
        r_div_shadow <= i_div;
        // A write landing on the boundary bypasses the shadow entirely.
        if (w_term) begin
          r_div_active   <= i_div;
          r_load_pending <= 1'b0;
        end else begin
          r_load_pending <= 1'b1;
        end
      end else if (r_load_pending && w_term) begin
        r_div_active   <= r_div_shadow;
        r_load_pending <= 1'b0;
      end else if (w_apply_idle) begin
        r_div_active   <= r_div_shadow;
        r_load_pending <= 1'b0;
        r_count        <= '0;
      end
    end
  end

  assign o_tick         = r_tick;
  assign o_clk_slow     = r_clk_slow;
  assign o_load_pending = r_load_pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers with a shared divisor-write port.
// Optional phase alignment via sync_pulse is built only with CLKDIV_PHASE_ALIGN_EN.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  clk_div_bank_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] w_we;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_clk_slow;
  logic [NUM_CH-1:0] w_load_pending;

`ifndef CLKDIV_PHASE_ALIGN_EN
  logic w_unused_sync;
  assign w_unused_sync = bus.sync_pulse;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(i);

    // Out-of-range selects match no channel and are dropped here.
    assign w_we[i] = bus.div_we && (bus.div_sel == CH_SEL);

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .i_en           (bus.enable[i]),
`ifdef CLKDIV_PHASE_ALIGN_EN
      .i_sync         (bus.sync_pulse),
`endif
      .i_we           (w_we[i]),
      .i_div          (bus.div_value),
      .o_tick         (w_tick[i]),
      .o_clk_slow     (w_clk_slow[i]),
      .o_load_pending (w_load_pending[i])
    );
  end

  assign bus.tick         = w_tick;
  assign bus.clk_slow     = w_clk_slow;
  assign bus.load_pending = w_load_pending;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed-vector bench for clk_div_bank (3 channels, reset divisor 4) with a queued scoreboard.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH = 3;

  typedef struct {
    int         id;
    logic [2:0] tick;
    logic [2:0] slow;
    logic [2:0] pend;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;
  int   step_id;

  clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CNT_W_DEFAULT)) bus ();

  clk_div_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (CNT_W_DEFAULT),
    .DEFAULT_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input logic rst, input logic [2:0] en, input logic we,
                      input logic [1:0] sel, input div_t val, input logic sy,
                      input logic [2:0] et, input logic [2:0] es, input logic [2:0] ep);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.enable     = en;
    bus.div_we     = we;
    bus.div_sel    = sel;
    bus.div_value  = val;
    bus.sync_pulse = sy;
    e.id   = step_id;
    e.tick = et;
    e.slow = es;
    e.pend = ep;
    sb_q.push_back(e);
    step_id++;
    @(posedge clk);
  endtask

  // Monitor: outputs are registered and present every cycle, one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks += 3;
        if (bus.tick !== e.tick) begin
          n_errors++;
          $display("FAIL tick step %0d: got %b expected %b", e.id, bus.tick, e.tick);
        end
        if (bus.clk_slow !== e.slow) begin
          n_errors++;
          $display("FAIL clk_slow step %0d: got %b expected %b", e.id, bus.clk_slow, e.slow);
        end
        if (bus.load_pending !== e.pend) begin
          n_errors++;
          $display("FAIL load_pending step %0d: got %b expected %b", e.id, bus.load_pending, e.pend);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    step_id  = 0;
    reset          = 1'b0;
    bus.enable     = '0;
    bus.div_we     = 1'b0;
    bus.div_sel    = '0;
    bus.div_value  = '0;
    bus.sync_pulse = 1'b0;

    // Reset and default divisor 4 on every channel
    step(1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);  // 0
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);  // 1
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000);  // 4
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000);  // 8
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    // ch1 <- 3 mid-count, applied at the next boundary
    step(0, 3'b111, 1, 1, 3, 0, 3'b000, 3'b000, 3'b010);  // 10
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000);  // 12
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b101, 3'b000);  // 15
    step(0, 3'b111, 0, 0, 0, 0, 3'b101, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);  // 18
    // ch2 <- 0 while disabled, then <- 1 while stopped
    step(0, 3'b011, 1, 2, 0, 0, 3'b000, 3'b010, 3'b100);  // 19
    step(0, 3'b011, 0, 0, 0, 0, 3'b001, 3'b011, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b001, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b001, 3'b000);
    step(0, 3'b111, 1, 2, 1, 0, 3'b000, 3'b001, 3'b100);  // 23
    step(0, 3'b111, 0, 0, 0, 0, 3'b011, 3'b010, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b100, 3'b110, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b100, 3'b010, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b110, 3'b100, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b101, 3'b001, 3'b000);  // 28
    step(0, 3'b111, 0, 0, 0, 0, 3'b100, 3'b101, 3'b000);
    // ch0 paused five cycles with count=1
    step(0, 3'b110, 0, 0, 0, 0, 3'b110, 3'b011, 3'b000);  // 30
    step(0, 3'b110, 0, 0, 0, 0, 3'b100, 3'b111, 3'b000);
    step(0, 3'b110, 0, 0, 0, 0, 3'b100, 3'b011, 3'b000);
    step(0, 3'b110, 0, 0, 0, 0, 3'b110, 3'b101, 3'b000);
    step(0, 3'b110, 0, 0, 0, 0, 3'b100, 3'b001, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b100, 3'b101, 3'b000);  // 35
    step(0, 3'b111, 0, 0, 0, 0, 3'b110, 3'b011, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b101, 3'b110, 3'b000);
    // reset with a simultaneous write: write dropped, all back to divisor 4
    step(1, 3'b111, 1, 0, 7, 0, 3'b000, 3'b000, 3'b000);  // 38
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000);  // 42
    // out-of-range select is ignored
    step(0, 3'b111, 1, 3, 2, 0, 3'b000, 3'b111, 3'b000);  // 43
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    // ch0 <- 2 on its boundary edge: active at once, never pending
    step(0, 3'b111, 1, 0, 2, 0, 3'b111, 3'b111, 3'b000);  // 50
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b001, 3'b110, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b110, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b001, 3'b000);  // 54
`ifdef CLKDIV_PHASE_ALIGN_EN
    // ch0 <- 4 pending, align applies it; ch1 <- 6 on align lands in shadow
    step(0, 3'b111, 1, 0, 4, 0, 3'b000, 3'b001, 3'b001);  // 55
    step(0, 3'b111, 1, 1, 6, 1, 3'b000, 3'b000, 3'b010);
    step(0, 3'b111, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000);  // 57
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b101, 3'b101, 3'b000);  // 61
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b111, 3'b000);  // 63
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b101, 3'b010, 3'b000);  // 65
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
    step(0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b101, 3'b000);  // 69
`endif

    @(negedge clk);
    bus.div_we     = 1'b0;
    bus.sync_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Bank of NUM_CH independent programmable clock dividers sharing one system clock.
- Each channel produces a one-cycle tick strobe and a 50%-duty toggle clock-enable level.
- Divisors are runtime-loadable through a shadow register and applied glitch-free at the period boundary.
- Successor to the fixed single-channel divider; feeds LED blinkers, debouncers and display scan logic.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 25, counter and divisor width in bits.
- DEFAULT_DIV, 25'd25_000_000, divisor loaded into every channel on reset (truncated to CNT_W).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  NUM_CH  per-channel run enable.
- div_we  in  1  one-cycle divisor write strobe.
- div_sel  in  $clog2(NUM_CH) (min 1)  target channel of the write.
- div_value  in  CNT_W  new divisor.
- sync_pulse  in  1  phase-align request (used only with the optional feature).
- tick  out  NUM_CH  one-cycle strobe per completed period.
- clk_slow  out  NUM_CH  toggles on each tick; period 2*div.
- load_pending  out  NUM_CH  shadow divisor written but not yet active.

Behaviour:
- Reset: synchronous and highest priority, including over div_we on the same edge.
  - Per channel: count=0, div_active=div_shadow=DEFAULT_DIV, tick=0, clk_slow=0, load_pending=0.
- All outputs are registered.
- Terminal event: enable[i]=1, div_active!=0 and count==div_active-1.
  - At that edge: count<=0, tick<=1, clk_slow<=~clk_slow.
  - Otherwise, when enabled: count<=count+1, tick<=0.
- First tick after reset release with enable held high occurs div_active cycles later; tick period = div_active; clk_slow period = 2*div_active.
- enable[i]=0: count and clk_slow hold; tick=0.
- div_active=0: channel stopped; count forced 0, tick 0, clk_slow forced 0.
- div_active=1: tick high every enabled cycle; clk_slow toggles every cycle.
- Divisor write (div_we=1, div_sel<NUM_CH):
  - div_shadow<=div_value, load_pending<=1.
  - div_sel>=NUM_CH: write ignored.
- Shadow apply: div_active<=div_shadow, load_pending<=0. Occurs when either:
  - a terminal event occurs, in which case count restarts at 0 with the new value; or
  - the channel is disabled or stopped (div_active=0), in which case the apply happens on the next edge and count<=0.
- Write coinciding with a terminal event: the written value bypasses the shadow and becomes active at that same edge; load_pending stays 0.
- Two writes before an apply: last write wins.
- Arithmetic:
  - Compare and increment in CNT_W bits, unsigned.
  - div_active-1 never underflows because the 0 case is excluded.
  - Counter never exceeds div_active-1, so no wrap.

Optional Feature:
- Macro: CLKDIV_PHASE_ALIGN_EN.
- Defined: sync_pulse=1 forces every channel's count<=0, tick<=0 and clk_slow<=0 on the next edge, and applies any pending shadow divisor.
  - Priority: below reset, above terminal events and divisor writes. A write in the same cycle lands in the shadow with load_pending=1.
  - Used to phase-align all channels.
- Undefined: sync_pulse is ignored; no logic is generated for it.

Decomposition:
- Package clk_div_pkg:
  - CNT_W_DEFAULT and DEFAULT_DIV_DEFAULT constants.
  - Typedef div_t (logic [CNT_W-1:0]).
- Sub-module clk_div_channel:
  - Implements one channel: counter, shadow/active divisor, tick, clk_slow, load_pending.
  - Top level generates NUM_CH instances and decodes div_we/div_sel into per-channel write strobes.

Test Plan:
- Reset, enable=all 1, defaults with DEFAULT_DIV=4 -> each tick high on cycles 4, 8, 12; clk_slow 0→1 at cycle 4, back to 0 at cycle 8.
- Write div_value=3 to ch1 while mid-count (count=1, div=4) -> load_pending[1]=1 until the next terminal edge; next ticks spaced 3 cycles; other channels unaffected.
- Write div_value=0 to ch2 while disabled -> applied next edge; tick[2] and clk_slow[2] stay 0 after re-enable. Then write 1 -> tick[2] high every cycle.
- Deassert enable[0] for 5 cycles mid-period -> count and clk_slow hold, no ticks; the period resumes with the remaining count. Then assert reset together with div_we -> all state returns to reset values and the write is dropped.
- div_sel=NUM_CH write -> no channel changes. Write coinciding with a terminal edge -> new divisor active immediately; load_pending stays 0.
- With CLKDIV_PHASE_ALIGN_EN defined, channels at divisors 4 and 6: sync_pulse -> all counts 0; ticks coincide again after 12 cycles.
